cpu_control_seq: RTL
====================

# cpu_control_seq

Registered, handshaked successor to the combinational CPU control decoder. It sits between IF/ID and ID/EX, accepts one opcode per valid/ready transfer and emits a registered control bundle. It expands CALL and RET into two sequenced control beats, supports downstream backpressure and pipeline flush, and optionally flags illegal opcodes.

## Interface
- ADD_OPCODE, 6'b100000, opcode_out used for address/SP increment
- SUB_OPCODE, 6'b100010, opcode_out used for SP decrement
- BCOND_NONE, 2'b11, branch_cond driven when not branching
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  reset, asynchronous assert, active-low
- opcode_in  input  6  opcode from IF/ID
- in_valid  input  1  opcode_in valid
- in_ready  output  1  block accepts opcode this cycle
- out_ready  input  1  ID/EX consumes bundle (low = stall)
- flush  input  1  synchronous kill of held and in-progress ops
- out_valid  output  1  control bundle valid
- seq_last  output  1  current beat is final beat of its instruction
- call, ret, branch, push, pop, reg_2_sel, mem_to_reg, mem_src, load_imm, sign_ext_sel, RegWrite, MemWrite, MemRead, OAMWrite, Read_Reg_1_en, Read_Reg_2_en  output  1 each  registered control
- branch_cond  output  2  branch condition
- alu_src  output  2  ALU operand select
- opcode_out  output  6  ALU opcode
- illegal_op  output  1  bundle came from reserved opcode (see Configuration)

## Operation
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready) && !flush.
- Decode (o = opcode_in). Fields not listed are 0, with branch_cond=BCOND_NONE and opcode_out=ADD_OPCODE.
- 1xxxxx ALU:
  - RegWrite=1, reg_2_sel=1, opcode_out=o, Read_Reg_1_en=1.
  - alu_src = o[1] ? (o[2] ? 10 : 00) : (o[0] ? 01 : 00).
  - Read_Reg_2_en = (alu_src==00).
- 0000bb branch: branch=1, branch_cond=bb, sign_ext_sel=1, alu_src=01.
- 0001x0 CALL:
  - Beat 1: RegWrite, MemWrite, mem_src, Read_Reg_1_en, sign_ext_sel =1; alu_src=10; opcode_out=SUB_OPCODE.
  - Beat 2: call=1, sign_ext_sel=1, seq_last=1.
- 0001x1 RET:
  - Beat 1: RegWrite, MemRead, Read_Reg_1_en, sign_ext_sel =1; alu_src=10; opcode_out=ADD_OPCODE.
  - Beat 2: ret=1, sign_ext_sel=1, seq_last=1.
- 0010pl LW/LI/POP:
  - RegWrite=1, reg_2_sel=1, Read_Reg_1_en=1.
  - mem_to_reg = MemRead = !l; load_imm = l.
  - p=1: pop=1, alu_src=10. p=0: alu_src=01.
- 0011px SW/PUSH:
  - MemWrite=1, Read_Reg_1_en=1, Read_Reg_2_en=1, RegWrite=p.
  - p=1: push=1, mem_src=1, alu_src=10, opcode_out=SUB_OPCODE. p=0: alu_src=01.
- 010xxx sprite: OAMWrite=1, alu_src=11.
- 011xxx reserved (audio): decoded as NOP with alu_src=11 and all writes 0.
- Single-beat instructions carry seq_last=1.
- FSM states: IDLE, CALL2, RET2.
  - IDLE: accepting CALL loads beat 1 and goes to CALL2; accepting RET loads beat 1 and goes to RET2; other opcodes stay in IDLE.
  - CALL2/RET2: when (!out_valid || out_ready), load beat 2 and return to IDLE. in_ready=0 while in CALL2/RET2.
- Output register holds its value while out_valid && !out_ready.
- When no new load occurs and out_ready, out_valid drops to 0 and all control outputs return to reset values (no stale writes).

## Timing
- Latency: opcode accepted at edge N, bundle visible after edge N (registered, 1 cycle).
- CALL/RET: beat 2 at the earliest one cycle after beat 1; each beat extends by stall cycles.
- Throughput: 1 instruction/cycle for single-beat ops; 2 cycles min for CALL/RET.
- Reset values (async, rst_n=0):
  - state=IDLE, out_valid=0, seq_last=0, illegal_op=0.
  - All 1-bit controls 0, alu_src=00, branch_cond=BCOND_NONE, opcode_out=ADD_OPCODE.
- Reset mid-CALL/RET: sequence abandoned; beat 2 never issued.
- flush=1 at an edge:
  - out_valid cleared and outputs set to reset values; state forced to IDLE.
  - No opcode accepted that cycle. flush has priority over every load.
- flush and out_ready together: flush wins; the held bundle counts as consumed.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: reserved 011xxx sets illegal_op=1 on its bundle (registered alongside it, cleared with out_valid/flush). The bundle is still a NOP.
- Undefined: illegal_op tied 0; reserved opcodes decode as NOP silently.

## Test plan
- Reset, then opcode 100001 with out_ready=1 -> next cycle out_valid=1, RegWrite=1, alu_src=01, Read_Reg_2_en=0, opcode_out=100001, seq_last=1.
- Opcode 000010 -> branch=1, branch_cond=10, alu_src=01, sign_ext_sel=1, RegWrite=0, opcode_out=100000.
- CALL 000100 with out_ready low 3 cycles after beat 1 -> beat 1 held unchanged (MemWrite=1, opcode_out=100010, seq_last=0), in_ready=0. Then beat 2 with call=1, seq_last=1. in_ready=1 after beat 2 is consumed.
- RET 000101, flush asserted while in RET2 -> out_valid=0 next cycle, ret never pulses, state IDLE, in_ready=1 the cycle after.
- PUSH 001110 then rst_n pulsed low mid-stall -> all outputs immediately at reset values, branch_cond=11, out_valid=0.
- Opcode 011000 -> with CTRL_ILLEGAL_TRAP_EN: illegal_op=1, all writes 0. Without it: illegal_op=0.

Source files
------------

// File: rtl/cpu_control_seq_if.sv
// Handshake and control-bundle bus between IF/ID, cpu_control_seq and ID/EX.
// master: upstream/downstream stage side; slave: the sequencer itself.
interface cpu_control_seq_if;
  logic [5:0] opcode_in;
  logic       in_valid;
  logic       in_ready;
  logic       out_ready;
  logic       flush;
  logic       out_valid;
  logic       seq_last;
  logic       call;
  logic       ret;
  logic       branch;
  logic       push;
  logic       pop;
  logic       reg_2_sel;
  logic       mem_to_reg;
  logic       mem_src;
  logic       load_imm;
  logic       sign_ext_sel;
  logic       RegWrite;
  logic       MemWrite;
  logic       MemRead;
  logic       OAMWrite;
  logic       Read_Reg_1_en;
  logic       Read_Reg_2_en;
  logic [1:0] branch_cond;
  logic [1:0] alu_src;
  logic [5:0] opcode_out;
  logic       illegal_op;

  modport master (
    output opcode_in, in_valid, out_ready, flush,
    input  in_ready, out_valid, seq_last, call, ret, branch, push, pop, reg_2_sel,
           mem_to_reg, mem_src, load_imm, sign_ext_sel, RegWrite, MemWrite, MemRead,
           OAMWrite, Read_Reg_1_en, Read_Reg_2_en, branch_cond, alu_src, opcode_out,
           illegal_op
  );

  modport slave (
    input  opcode_in, in_valid, out_ready, flush,
    output in_ready, out_valid, seq_last, call, ret, branch, push, pop, reg_2_sel,
           mem_to_reg, mem_src, load_imm, sign_ext_sel, RegWrite, MemWrite, MemRead,
           OAMWrite, Read_Reg_1_en, Read_Reg_2_en, branch_cond, alu_src, opcode_out,
           illegal_op
  );
endinterface

// File: rtl/cpu_control_seq.sv
// Registered, handshaked CPU control decoder. Accepts one opcode per valid/ready
// transfer, expands CALL/RET into two beats, honours backpressure and flush.
// Optional feature: define CTRL_ILLEGAL_TRAP_EN to flag reserved 011xxx opcodes.
module cpu_control_seq (
  input logic              clk,
  input logic              rst_n,
  cpu_control_seq_if.slave bus
);

  localparam logic [5:0] AddOpcode = 6'b100000;
  localparam logic [5:0] SubOpcode = 6'b100010;
  localparam logic [1:0] BcondNone = 2'b11;

  typedef enum logic [1:0] {StIdle, StCall2, StRet2} state_e;

  typedef struct packed {
    logic       call;
    logic       ret;
    logic       branch;
    logic       push;
    logic       pop;
    logic       reg_2_sel;
    logic       mem_to_reg;
    logic       mem_src;
    logic       load_imm;
    logic       sign_ext_sel;
    logic       reg_write;
    logic       mem_write;
    logic       mem_read;
    logic       oam_write;
    logic       rd_reg_1_en;
    logic       rd_reg_2_en;
    logic [1:0] branch_cond;
    logic [1:0] alu_src;
    logic [5:0] opcode_out;
    logic       seq_last;
    logic       illegal_op;
  } ctrl_t;

  // Quiescent bundle: no writes, no branch, ALU defaults to add.
  function automatic ctrl_t ctrl_idle();
    ctrl_t c;
    c             = '0;
    c.branch_cond = BcondNone;
    c.opcode_out  = AddOpcode;
    return c;
  endfunction

  // First (or only) beat for an opcode.
  function automatic ctrl_t decode_beat1(input logic [5:0] o);
    ctrl_t c;
    c          = ctrl_idle();
    c.seq_last = 1'b1;
    unique casez (o)
      6'b1?????: begin
        c.reg_write   = 1'b1;
        c.reg_2_sel   = 1'b1;
        c.opcode_out  = o;
        c.rd_reg_1_en = 1'b1;
        c.alu_src     = o[1] ? (o[2] ? 2'b10 : 2'b00) : (o[0] ? 2'b01 : 2'b00);
        c.rd_reg_2_en = (c.alu_src == 2'b00);
      end
      6'b0000??: begin
        c.branch       = 1'b1;
        c.branch_cond  = o[1:0];
        c.sign_ext_sel = 1'b1;
        c.alu_src      = 2'b01;
      end
      6'b0001?0: begin
        // CALL beat 1: push return address, SP decrement
        c.reg_write    = 1'b1;
        c.mem_write    = 1'b1;
        c.mem_src      = 1'b1;
        c.rd_reg_1_en  = 1'b1;
        c.sign_ext_sel = 1'b1;
        c.alu_src      = 2'b10;
        c.opcode_out   = SubOpcode;
        c.seq_last     = 1'b0;
      end
      6'b0001?1: begin
        // RET beat 1: pop return address, SP increment
        c.reg_write    = 1'b1;
        c.mem_read     = 1'b1;
        c.rd_reg_1_en  = 1'b1;
        c.sign_ext_sel = 1'b1;
        c.alu_src      = 2'b10;
        c.opcode_out   = AddOpcode;
        c.seq_last     = 1'b0;
      end
      6'b0010??: begin
        c.reg_write   = 1'b1;
        c.reg_2_sel   = 1'b1;
        c.rd_reg_1_en = 1'b1;
        c.mem_to_reg  = ~o[0];
        c.mem_read    = ~o[0];
        c.load_imm    = o[0];
        c.pop         = o[1];
        c.alu_src     = o[1] ? 2'b10 : 2'b01;
      end
      6'b0011??: begin
        c.mem_write   = 1'b1;
        c.rd_reg_1_en = 1'b1;
        c.rd_reg_2_en = 1'b1;
        c.reg_write   = o[1];
        c.push        = o[1];
        c.mem_src     = o[1];
        c.alu_src     = o[1] ? 2'b10 : 2'b01;
        c.opcode_out  = o[1] ? SubOpcode : AddOpcode;
      end
      6'b010???: begin
        c.oam_write = 1'b1;
        c.alu_src   = 2'b11;
      end
      default: begin
        // Reserved audio space: NOP with no writes
        c.alu_src = 2'b11;
`ifdef CTRL_ILLEGAL_TRAP_EN
        c.illegal_op = 1'b1;
`else
        c.illegal_op = 1'b0;
`endif
      end
    endcase
    return c;
  endfunction

  function automatic ctrl_t beat2(input logic is_call);
    ctrl_t c;
    c              = ctrl_idle();
    c.call         = is_call;
    c.ret          = ~is_call;
    c.sign_ext_sel = 1'b1;
    c.seq_last     = 1'b1;
    return c;
  endfunction

  state_e state_q, state_d;
  ctrl_t  ctrl_q, ctrl_d;
  logic   out_valid_q, out_valid_d;
  logic   can_load, in_ready, accept, op_call, op_ret;

  assign can_load = ~out_valid_q | bus.out_ready;
  assign in_ready = (state_q == StIdle) & can_load & ~bus.flush;
  assign accept   = bus.in_valid & in_ready;
  assign op_call  = (bus.opcode_in[5:2] == 4'b0001) & ~bus.opcode_in[0];
  assign op_ret   = (bus.opcode_in[5:2] == 4'b0001) & bus.opcode_in[0];

  // State and output register; reset abandons any CALL/RET in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      out_valid_q <= 1'b0;
      ctrl_q      <= ctrl_idle();
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
    end
  end

  // Next-state: flush forces IDLE; second beat issues once the first is consumed.
  always_comb begin
    state_d = state_q;
    if (bus.flush) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept && op_call)     state_d = StCall2;
          else if (accept && op_ret) state_d = StRet2;
        end
        StCall2, StRet2: begin
          if (can_load) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Next output bundle: flush > new opcode > second beat > drain > hold.
  always_comb begin
    ctrl_d      = ctrl_q;
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      ctrl_d      = ctrl_idle();
      out_valid_d = 1'b0;
    end else if (accept) begin
      ctrl_d      = decode_beat1(bus.opcode_in);
      out_valid_d = 1'b1;
    end else if ((state_q != StIdle) && can_load) begin
      ctrl_d      = beat2(state_q == StCall2);
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      // Consumed with nothing behind it: drop to idle so no write repeats
      ctrl_d      = ctrl_idle();
      out_valid_d = 1'b0;
    end
  end

  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.seq_last      = ctrl_q.seq_last;
  assign bus.call          = ctrl_q.call;
  assign bus.ret           = ctrl_q.ret;
  assign bus.branch        = ctrl_q.branch;
  assign bus.push          = ctrl_q.push;
  assign bus.pop           = ctrl_q.pop;
  assign bus.reg_2_sel     = ctrl_q.reg_2_sel;
  assign bus.mem_to_reg    = ctrl_q.mem_to_reg;
  assign bus.mem_src       = ctrl_q.mem_src;
  assign bus.load_imm      = ctrl_q.load_imm;
  assign bus.sign_ext_sel  = ctrl_q.sign_ext_sel;
  assign bus.RegWrite      = ctrl_q.reg_write;
  assign bus.MemWrite      = ctrl_q.mem_write;
  assign bus.MemRead       = ctrl_q.mem_read;
  assign bus.OAMWrite      = ctrl_q.oam_write;
  assign bus.Read_Reg_1_en = ctrl_q.rd_reg_1_en;
  assign bus.Read_Reg_2_en = ctrl_q.rd_reg_2_en;
  assign bus.branch_cond   = ctrl_q.branch_cond;
  assign bus.alu_src       = ctrl_q.alu_src;
  assign bus.opcode_out    = ctrl_q.opcode_out;
  assign bus.illegal_op    = ctrl_q.illegal_op;

endmodule
